// File: rtl/loop_pkg.sv
// ---------------------------------------------------------------------------
// loop_pkg : width defaults and mul/add select encodings shared with the
//            upstream loop controller.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loop_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 10;

    // mul_sel encodings
    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_X2   = 2'b01;
    localparam logic [1:0] SEL_X5   = 2'b10;
    localparam logic [1:0] SEL_CXS  = 2'b11;

    // add_sel encodings; 2'b10 aliases ADD_AP
    localparam logic [1:0] ADD_PASS = 2'b00;
    localparam logic [1:0] ADD_AP   = 2'b01;
    localparam logic [1:0] ADD_AB   = 2'b11;

endpackage

`default_nettype wire

// File: rtl/loop_alu.sv
// ---------------------------------------------------------------------------
// loop_alu : combinational multiply/add result selection for loop_datapath.
//            rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module loop_alu
    import loop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] reg_c,
    input  logic [DATA_W-1:0] reg_p,
    input  logic [DATA_W-1:0] reg_s,
    input  logic [1:0]        mul_sel,
    input  logic [1:0]        add_sel,
    output logic [DATA_W-1:0] mul_result,
    output logic [DATA_W-1:0] add_result
);

    logic [DATA_W-1:0] cxs;

    // Product keeps only the low DATA_W bits (modulo 2^DATA_W).
    assign cxs = reg_c * reg_s;

    always_comb begin
        mul_result = reg_b;
        case (mul_sel)
            SEL_PASS: mul_result = reg_b;
            SEL_X2:   mul_result = reg_b << 1;
            SEL_X5:   mul_result = reg_b + (reg_b << 2);
            SEL_CXS:  mul_result = cxs;
            default:  mul_result = reg_b;
        endcase
    end

    always_comb begin
        add_result = reg_a;
        case (add_sel)
            ADD_PASS: add_result = reg_a;
            ADD_AB:   add_result = reg_a + reg_b;
            default:  add_result = reg_a + reg_p;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/loop_datapath.sv
// ---------------------------------------------------------------------------
// loop_datapath : operand/result registers, element index and guarded store
//                 port for a controller-sequenced loop.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module loop_datapath
    import loop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_a_en,
    input  logic              load_b_en,
    input  logic              load_c_en,
    input  logic              mul_en,
    input  logic [1:0]        mul_sel,
    input  logic              add_en,
    input  logic [1:0]        add_sel,
    input  logic              store_c_en,
    input  logic [31:0]       n,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    input  logic [DATA_W-1:0] c_rdata,
    output logic              c_we,
    output logic [DATA_W-1:0] c_wdata,
    output logic [31:0]       idx,
    output logic              err
);

    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] reg_c;
    logic [DATA_W-1:0] reg_p;
    logic [DATA_W-1:0] reg_s;
    logic [DATA_W-1:0] mul_result;
    logic [DATA_W-1:0] add_result;
    logic              in_range;
    logic              store_ok;
    logic              store_bad;

    loop_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .reg_c      (reg_c),
        .reg_p      (reg_p),
        .reg_s      (reg_s),
        .mul_sel    (mul_sel),
        .add_sel    (add_sel),
        .mul_result (mul_result),
        .add_result (add_result)
    );

    assign in_range  = (idx < n);
    assign store_ok  = store_c_en && in_range;
    assign store_bad = store_c_en && !in_range;

    // Memory reads and the store share the pre-increment index.
    assign a_addr  = idx[ADDR_W-1:0];
    assign b_addr  = idx[ADDR_W-1:0];
    assign c_addr  = idx[ADDR_W-1:0];
    assign c_we    = store_ok && !rst;
    assign c_wdata = reg_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
            reg_p <= '0;
            reg_s <= '0;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            if (load_a_en) reg_a <= a_rdata;
            if (load_b_en) reg_b <= b_rdata;
            if (load_c_en) reg_c <= c_rdata;
            if (mul_en)    reg_p <= mul_result;
            if (add_en)    reg_s <= add_result;
            if (store_ok)  idx   <= idx + 32'd1;
            if (store_bad) err   <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_loop_datapath.sv
// ---------------------------------------------------------------------------
// tb_loop_datapath : directed self-checking bench for loop_datapath.
//                    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_loop_datapath;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_a_en, load_b_en, load_c_en;
    logic          mul_en, add_en, store_c_en;
    logic [1:0]    mul_sel, add_sel;
    logic [31:0]   n;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_rdata, b_rdata, c_rdata;
    logic          c_we;
    logic [DW-1:0] c_wdata;
    logic [31:0]   idx;
    logic          err;

    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];
    logic [DW-1:0] c_mem [16];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign a_rdata = a_mem[a_addr[3:0]];
    assign b_rdata = b_mem[b_addr[3:0]];
    assign c_rdata = c_mem[c_addr[3:0]];

    loop_datapath #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_a_en  (load_a_en),
        .load_b_en  (load_b_en),
        .load_c_en  (load_c_en),
        .mul_en     (mul_en),
        .mul_sel    (mul_sel),
        .add_en     (add_en),
        .add_sel    (add_sel),
        .store_c_en (store_c_en),
        .n          (n),
        .a_addr     (a_addr),
        .b_addr     (b_addr),
        .c_addr     (c_addr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .c_rdata    (c_rdata),
        .c_we       (c_we),
        .c_wdata    (c_wdata),
        .idx        (idx),
        .err        (err)
    );

    task automatic clr();
        load_a_en = 0; load_b_en = 0; load_c_en = 0;
        mul_en = 0; add_en = 0; store_c_en = 0;
        mul_sel = 2'b00; add_sel = 2'b00;
    endtask

    // Apply the driven controls for one rising edge, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic load_all();
        load_a_en = 1; load_b_en = 1; load_c_en = 1; tick();
    endtask

    task automatic do_mul(input logic [1:0] sel);
        mul_en = 1; mul_sel = sel; tick();
    endtask

    task automatic do_add(input logic [1:0] sel);
        add_en = 1; add_sel = sel; tick();
    endtask

    task automatic test_reset();
        rst = 1; n = 32'd4; clr();
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b0) begin errors++; $display("FAIL reset_we: c_we=%0b required 0", c_we); end
        tick();
        tick();
        checks++;
        if (idx !== 32'd0 || err !== 1'b0 || c_wdata !== 32'd0 || a_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: idx=%0d err=%0b c_wdata=%0d a_addr=%0d required 0/0/0/0", idx, err, c_wdata, a_addr);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        load_all();
        do_mul(2'b01);
        do_add(2'b01);
        do_mul(2'b11);
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b1 || c_addr !== 10'd0 || c_wdata !== 32'd77) begin
            errors++;
            $display("FAIL basic_store: we=%0b addr=%0d data=%0d required 1/0/77", c_we, c_addr, c_wdata);
        end
        tick();
        checks++;
        if (idx !== 32'd1) begin errors++; $display("FAIL basic_idx: idx=%0d required 1", idx); end
    endtask

    task automatic test_variant();
        load_all();
        do_mul(2'b10);
        checks++;
        if (c_wdata !== 32'd20) begin errors++; $display("FAIL x5: p=%0d required 20", c_wdata); end
        do_add(2'b10);
        do_mul(2'b11);
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b1 || c_addr !== 10'd1 || c_wdata !== 32'd161) begin
            errors++;
            $display("FAIL variant_store: we=%0b addr=%0d data=%0d required 1/1/161", c_we, c_addr, c_wdata);
        end
        tick();
        checks++;
        if (idx !== 32'd2) begin errors++; $display("FAIL variant_idx: idx=%0d required 2", idx); end
    endtask

    task automatic test_truncate();
        load_all();
        do_add(2'b00);
        do_mul(2'b11);
        checks++;
        if (c_wdata !== 32'd0) begin errors++; $display("FAIL trunc: p=0x%08h required 0", c_wdata); end
        do_mul(2'b00);
        checks++;
        if (c_wdata !== 32'd6) begin errors++; $display("FAIL pass_b: p=%0d required 6", c_wdata); end
        // Concurrent mul/add: the add must see p=6, not the new p=12.
        mul_en = 1; mul_sel = 2'b01; add_en = 1; add_sel = 2'b01; tick();
        checks++;
        if (c_wdata !== 32'd12 || err !== 1'b0) begin
            errors++;
            $display("FAIL concurrent_p: p=%0d err=%0b required 12/0", c_wdata, err);
        end
        do_mul(2'b11);
        checks++;
        if (c_wdata !== 32'h0006_0000) begin errors++; $display("FAIL concurrent_s: p=0x%08h required 0x00060000", c_wdata); end
    endtask

    task automatic test_store_with_load();
        a_mem[2] = 32'd9;
        load_a_en = 1; store_c_en = 1;
        #1;
        checks++;
        if (a_addr !== 10'd2 || c_we !== 1'b1 || c_addr !== 10'd2 || c_wdata !== 32'h0006_0000) begin
            errors++;
            $display("FAIL load_store_cycle: a_addr=%0d we=%0b c_addr=%0d data=0x%08h required 2/1/2/0x00060000", a_addr, c_we, c_addr, c_wdata);
        end
        tick();
        checks++;
        if (idx !== 32'd3) begin errors++; $display("FAIL load_store_idx: idx=%0d required 3", idx); end
        do_add(2'b00);
        do_mul(2'b11);
        checks++;
        if (c_wdata !== 32'h0009_0000) begin errors++; $display("FAIL load_store_a: p=0x%08h required 0x00090000", c_wdata); end
    endtask

    task automatic test_bound();
        rst = 1; tick(); rst = 0;
        n = 32'd1;
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b1 || c_addr !== 10'd0) begin errors++; $display("FAIL bound_first: we=%0b addr=%0d required 1/0", c_we, c_addr); end
        tick();
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b0) begin errors++; $display("FAIL bound_second_we: c_we=%0b required 0", c_we); end
        tick();
        checks++;
        if (idx !== 32'd1 || err !== 1'b1) begin errors++; $display("FAIL bound_err: idx=%0d err=%0b required 1/1", idx, err); end
        tick(); tick();
        checks++;
        if (err !== 1'b1 || idx !== 32'd1) begin errors++; $display("FAIL bound_sticky: idx=%0d err=%0b required 1/1", idx, err); end
        rst = 1; tick(); rst = 0;
        checks++;
        if (err !== 1'b0 || idx !== 32'd0) begin errors++; $display("FAIL bound_clear: idx=%0d err=%0b required 0/0", idx, err); end
    endtask

    task automatic test_mid_reset();
        n = 32'd4;
        load_all();
        do_mul(2'b01);
        do_add(2'b01);
        rst = 1; mul_en = 1; mul_sel = 2'b11; store_c_en = 1; load_a_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b0) begin errors++; $display("FAIL midrst_we: c_we=%0b required 0", c_we); end
        tick();
        rst = 0;
        checks++;
        if (idx !== 32'd0 || err !== 1'b0 || c_wdata !== 32'd0) begin
            errors++;
            $display("FAIL midrst_state: idx=%0d err=%0b p=%0d required 0/0/0", idx, err, c_wdata);
        end
        do_mul(2'b00);
        checks++;
        if (c_wdata !== 32'd0) begin errors++; $display("FAIL midrst_b: p=%0d required 0", c_wdata); end
        load_all();
        do_mul(2'b01);
        do_add(2'b01);
        do_mul(2'b11);
        store_c_en = 1;
        #1;
        checks++;
        if (c_we !== 1'b1 || c_addr !== 10'd0 || c_wdata !== 32'd77) begin
            errors++;
            $display("FAIL midrst_rerun: we=%0b addr=%0d data=%0d required 1/0/77", c_we, c_addr, c_wdata);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 32'd0; b_mem[i] = 32'd0; c_mem[i] = 32'd0;
        end
        a_mem[0] = 32'd3; b_mem[0] = 32'd4; c_mem[0] = 32'd7;
        a_mem[1] = 32'd3; b_mem[1] = 32'd4; c_mem[1] = 32'd7;
        a_mem[2] = 32'h0001_0000; b_mem[2] = 32'd6; c_mem[2] = 32'h0001_0000;

        test_reset();
        test_basic();
        test_variant();
        test_truncate();
        test_store_with_load();
        test_bound();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
